// File: rtl/la_capture.sv
// -----------------------------------------------------------------------------
// la_capture -- in-fabric logic-analyser capture engine.
//
// Samples a DATA_W-wide probe bus every clock into a DEPTH-word circular
// buffer. The trigger is a masked level match, masked edge, masked any-change,
// or a force. A programmable number of pre-trigger samples is kept, and the
// buffer is read back oldest-first once the capture is DONE.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_data            probe bus
//   i_arm, i_abort    start capture (pulse) / return to IDLE (highest priority)
//   i_trig_mode       0=level 1=edge 2=change 3=force
//   i_trig_mask       bits taking part in the trigger
//   i_trig_value      compare value for level/edge
//   i_pretrig         samples kept before the trigger
//   o_armed           PRE or WAIT_TRIG
//   o_triggered       POST or DONE
//   o_done            DONE
//   o_trig_addr       physical buffer address of the trigger sample
//   i_rd_en, i_rd_addr  read request, logical index (0 = oldest)
//   o_rd_data, o_rd_valid  read data, one cycle after the request
// -----------------------------------------------------------------------------
module la_capture #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic [1:0]        i_trig_mode,
  input  logic [DATA_W-1:0] i_trig_mask,
  input  logic [DATA_W-1:0] i_trig_value,
  input  logic [ADDR_W-1:0] i_pretrig,
  output logic              o_armed,
  output logic              o_triggered,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_trig_addr,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_W-1:0] MAX_PRE = ADDR_W'(DEPTH - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_pretrig;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_value;
  logic [DATA_W-1:0] r_prev_data;
  logic              r_prev_match;
  logic              r_first;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_arm_go;
  logic              w_capturing;
  logic              w_we;
  logic              w_rd_go;
  logic [DATA_W-1:0] w_cfg_mask;
  logic [DATA_W-1:0] w_cfg_value;
  logic              w_match;
  logic              w_change;
  logic              w_trig;
  logic [ADDR_W-1:0] w_post_init;
  logic [ADDR_W-1:0] w_rd_phys;

  // i_pretrig is ADDR_W bits wide and DEPTH is a power of two, so the port
  // itself already limits the value to DEPTH-1; no further clamp is needed.
  assign w_arm_go    = i_arm & ~i_abort & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_capturing = (r_state == S_PRE) | (r_state == S_WAIT) | (r_state == S_POST);
  assign w_we        = w_capturing & ~i_abort;
  assign w_rd_go     = i_rd_en & ~i_abort & (r_state == S_DONE);

  // On the arm edge the new configuration is already used for prev_match, so
  // an edge trigger compares against the mask/value it was armed with.
  assign w_cfg_mask  = w_arm_go ? i_trig_mask  : r_mask;
  assign w_cfg_value = w_arm_go ? i_trig_value : r_value;
  assign w_match     = ((i_data ^ w_cfg_value) & w_cfg_mask) == {DATA_W{1'b0}};
  assign w_change    = ((i_data ^ r_prev_data) & r_mask) != {DATA_W{1'b0}};
  assign w_post_init = MAX_PRE - r_pretrig;
  assign w_rd_phys   = r_trig_addr - r_pretrig + i_rd_addr;

  // Trigger condition selected by the latched mode.
  always_comb begin
    w_trig = 1'b0;
    case (r_mode)
      2'd0:    w_trig = w_match;
      2'd1:    w_trig = w_match & ~r_prev_match;
      2'd2:    w_trig = w_change;
      2'd3:    w_trig = r_first;
      default: w_trig = 1'b0;
    endcase
  end

  // Capture FSM, pointers, counters, configuration and history registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= {ADDR_W{1'b0}};
      r_pre_cnt    <= {ADDR_W{1'b0}};
      r_post_cnt   <= {ADDR_W{1'b0}};
      r_pretrig    <= {ADDR_W{1'b0}};
      r_trig_addr  <= {ADDR_W{1'b0}};
      r_mode       <= 2'd0;
      r_mask       <= {DATA_W{1'b0}};
      r_value      <= {DATA_W{1'b0}};
      r_prev_data  <= {DATA_W{1'b0}};
      r_prev_match <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      r_prev_data  <= i_data;
      r_prev_match <= w_match;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_first <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (i_arm) begin
              r_mode    <= i_trig_mode;
              r_mask    <= i_trig_mask;
              r_value   <= i_trig_value;
              r_pretrig <= i_pretrig;
              r_pre_cnt <= i_pretrig;
              r_wr_ptr  <= {ADDR_W{1'b0}};
              r_first   <= 1'b1;
              r_state   <= (i_pretrig == {ADDR_W{1'b0}}) ? S_WAIT : S_PRE;
            end
          end
          S_PRE: begin
            // Trigger conditions are not looked at while filling pre-history.
            r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
            r_pre_cnt <= r_pre_cnt - ADDR_W'(1);
            if (r_pre_cnt == ADDR_W'(1)) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_first  <= 1'b0;
            if (w_trig) begin
              // The sample written this cycle is the trigger sample.
              r_trig_addr <= r_wr_ptr;
              r_post_cnt  <= w_post_init;
              r_state     <= (w_post_init == {ADDR_W{1'b0}}) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
            r_post_cnt <= r_post_cnt - ADDR_W'(1);
            if (r_post_cnt == ADDR_W'(1)) begin
              r_state <= S_DONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Sample buffer write port (no reset so it maps onto block RAM).
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Synchronous readout; data holds when no read is performed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data  <= {DATA_W{1'b0}};
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      if (w_rd_go) begin
        r_rd_data <= r_mem[w_rd_phys];
      end
    end
  end

  assign o_armed     = (r_state == S_PRE) | (r_state == S_WAIT);
  assign o_triggered = (r_state == S_POST) | (r_state == S_DONE);
  assign o_done      = (r_state == S_DONE);
  assign o_trig_addr = r_trig_addr;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_la_capture.sv
module tb_la_capture;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic          i_arm = 1'b0;
  logic          i_abort = 1'b0;
  logic [1:0]    i_trig_mode = 2'd0;
  logic [DW-1:0] i_trig_mask = '0;
  logic [DW-1:0] i_trig_value = '0;
  logic [AW-1:0] i_pretrig = '0;
  logic          o_armed, o_triggered, o_done, o_rd_valid;
  logic [AW-1:0] o_trig_addr;
  logic          i_rd_en = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic [DW-1:0] o_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  la_capture #(.DATA_W(DW), .DEPTH(DP)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_arm(i_arm), .i_abort(i_abort),
    .i_trig_mode(i_trig_mode), .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value),
    .i_pretrig(i_pretrig), .o_armed(o_armed), .o_triggered(o_triggered), .o_done(o_done),
    .o_trig_addr(o_trig_addr), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] mask;
    logic [7:0] value;
    logic [3:0] pretrig;
    logic [7:0] pre_val;
    logic [7:0] start;
    int         stp;
    int         nsamp;
    logic [3:0] taddr;
    logic [7:0] k0;
    logic [7:0] kp;
    logic [7:0] k15;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic arm(input logic [1:0] mode, input logic [7:0] mask,
                     input logic [7:0] value, input logic [3:0] pre);
    i_trig_mode = mode; i_trig_mask = mask; i_trig_value = value; i_pretrig = pre;
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    // Scramble configuration to show it was latched on the arm edge.
    i_trig_mode = ~mode; i_trig_value = ~value; i_trig_mask = ~mask; i_pretrig = pre + 4'd3;
  endtask

  task automatic read_k(input string name, input logic [3:0] k, input logic [7:0] exp);
    i_rd_en = 1'b1; i_rd_addr = k;
    step();
    i_rd_en = 1'b0;
    check({name, "_valid"}, {31'd0, o_rd_valid}, 32'd1);
    check({name, "_data"}, {24'd0, o_rd_data}, {24'd0, exp});
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int done_at;
    int t;
    logic [7:0] e;
    i_data = v.pre_val;
    step(); step();
    arm(v.mode, v.mask, v.value, v.pretrig);
    done_at = 0;
    for (int i = 0; i < 400 && done_at == 0; i++) begin
      i_data = 8'(int'(v.start) + v.stp * i);
      step();
      if (o_done) done_at = i + 1;
    end
    check($sformatf("v%0d_nsamp", idx), done_at, v.nsamp);
    check($sformatf("v%0d_taddr", idx), {28'd0, o_trig_addr}, {28'd0, v.taddr});
    check($sformatf("v%0d_flags", idx), {29'd0, o_armed, o_triggered, o_done}, 32'd3);
    // Back-to-back readout of the whole buffer, oldest first.
    t = v.nsamp - 1 - (DP - 1 - int'(v.pretrig));
    i_rd_en = 1'b1;
    for (int k = 0; k < DP; k++) begin
      i_rd_addr = 4'(k);
      step();
      e = 8'(int'(v.start) + v.stp * (t - int'(v.pretrig) + k));
      check($sformatf("v%0d_rdv_k%0d", idx, k), {31'd0, o_rd_valid}, 32'd1);
      check($sformatf("v%0d_rd_k%0d", idx, k), {24'd0, o_rd_data}, {24'd0, e});
      if (k == 0) check($sformatf("v%0d_k0", idx), {24'd0, o_rd_data}, {24'd0, v.k0});
      if (k == int'(v.pretrig)) check($sformatf("v%0d_kp", idx), {24'd0, o_rd_data}, {24'd0, v.kp});
      if (k == DP - 1) check($sformatf("v%0d_k15", idx), {24'd0, o_rd_data}, {24'd0, v.k15});
    end
    i_rd_en = 1'b0;
    step();
    check($sformatf("v%0d_noread_valid", idx), {31'd0, o_rd_valid}, 32'd0);
    check($sformatf("v%0d_noread_hold", idx), {24'd0, o_rd_data}, {24'd0, v.k15});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   done_at;
    // mode mask value pre pre_val start stp nsamp taddr k0 kp k15
    vecs[0] = '{2'd0, 8'hFF, 8'h0A, 4'd4,  8'hEE, 8'h00, 1, 22,  4'd10, 8'h06, 8'h0A, 8'h15};
    vecs[1] = '{2'd0, 8'hFF, 8'h28, 4'd8,  8'hEE, 8'h00, 1, 48,  4'd8,  8'h20, 8'h28, 8'h2F};
    vecs[2] = '{2'd3, 8'h00, 8'h00, 4'd0,  8'hEE, 8'h33, 1, 16,  4'd0,  8'h33, 8'h33, 8'h42};
    vecs[3] = '{2'd3, 8'h00, 8'h00, 4'd15, 8'hEE, 8'h50, 1, 16,  4'd15, 8'h50, 8'h5F, 8'h5F};
    vecs[4] = '{2'd2, 8'h01, 8'h00, 4'd0,  8'h10, 8'h11, 1, 16,  4'd0,  8'h11, 8'h11, 8'h20};
    vecs[5] = '{2'd0, 8'hFF, 8'h03, 4'd4,  8'hEE, 8'h00, 1, 271, 4'd3,  8'hFF, 8'h03, 8'h0E};
    vecs[6] = '{2'd1, 8'h0F, 8'h05, 4'd3,  8'h00, 8'h00, 1, 18,  4'd5,  8'h02, 8'h05, 8'h11};

    // Reset state.
    #12;
    check("rst_flags", {29'd0, o_armed, o_triggered, o_done}, 32'd0);
    check("rst_taddr", {28'd0, o_trig_addr}, 32'd0);
    check("rst_rd", {23'd0, o_rd_valid, o_rd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0;
    check("idle_read_valid", {31'd0, o_rd_valid}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Edge vs level: 0A held, then 00, then 0A triggers. Arm in WAIT ignored.
    i_data = 8'h0A;
    step(); step();
    arm(2'd1, 8'hFF, 8'h0A, 4'd2);
    for (int i = 0; i < 5; i++) begin
      i_data = 8'h0A;
      if (i == 3) i_arm = 1'b1;
      step();
      i_arm = 1'b0;
      check($sformatf("edge_hold%0d_trig", i), {31'd0, o_triggered}, 32'd0);
    end
    check("edge_armed", {31'd0, o_armed}, 32'd1);
    i_data = 8'h00;
    step();
    check("edge_zero_trig", {31'd0, o_triggered}, 32'd0);
    i_data = 8'h0A;
    step();
    check("edge_fire_trig", {31'd0, o_triggered}, 32'd1);
    check("edge_taddr", {28'd0, o_trig_addr}, 32'd6);
    done_at = 0;
    for (int i = 0; i < 40 && done_at == 0; i++) begin
      i_data = 8'h77;
      step();
      if (o_done) done_at = i + 1;
    end
    check("edge_post_len", done_at, 13);
    read_k("edge_k2", 4'd2, 8'h0A);
    read_k("edge_k1", 4'd1, 8'h00);
    read_k("edge_k0", 4'd0, 8'h0A);
    read_k("edge_k3", 4'd3, 8'h77);

    // Change mode: mask-excluded changes never trigger; then abort in POST.
    i_data = 8'h20;
    step();
    arm(2'd2, 8'h01, 8'h00, 4'd3);
    for (int i = 0; i < 20; i++) begin
      i_data = 8'(8'h20 + 2 * i);
      step();
    end
    check("chg_masked_trig", {31'd0, o_triggered}, 32'd0);
    check("chg_masked_armed", {31'd0, o_armed}, 32'd1);
    i_data = 8'h49;
    step();
    check("chg_fire_trig", {31'd0, o_triggered}, 32'd1);
    check("chg_taddr", {28'd0, o_trig_addr}, 32'd4);
    step(); step();
    check("post_flags", {29'd0, o_armed, o_triggered, o_done}, 32'd2);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_flags", {29'd0, o_armed, o_triggered, o_done}, 32'd0);
    check("abort_taddr_kept", {28'd0, o_trig_addr}, 32'd4);
    i_rd_en = 1'b1; i_rd_addr = 4'd0;
    step();
    i_rd_en = 1'b0;
    check("abort_read_valid", {31'd0, o_rd_valid}, 32'd0);
    check("abort_read_hold", {24'd0, o_rd_data}, 32'h77);

    // Async reset mid-POST, observed between clock edges.
    arm(2'd3, 8'h00, 8'h00, 4'd0);
    for (int i = 0; i < 4; i++) begin
      i_data = 8'(i);
      step();
    end
    check("pre_rst_trig", {31'd0, o_triggered}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_flags", {29'd0, o_armed, o_triggered, o_done}, 32'd0);
    check("async_rst_taddr", {28'd0, o_trig_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // abort + arm in IDLE stays IDLE.
    i_trig_mode = 2'd3; i_pretrig = 4'd0;
    i_arm = 1'b1; i_abort = 1'b1;
    step();
    i_arm = 1'b0; i_abort = 1'b0;
    step();
    check("abort_arm_idle", {29'd0, o_armed, o_triggered, o_done}, 32'd0);

    // Fresh capture after reset.
    run_vec(7, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/la_capture.md
Name: la_capture

Overview:
- Parametrised in-fabric logic-analyser capture engine for probing design nets such as the 7-segment counter and segment outputs, with no vendor debug core.
- Samples a DATA_W-wide probe bus every i_clk cycle into a circular buffer of DEPTH words.
- Trigger is programmable: masked level match, masked edge, masked any-change, or force.
- Keeps a programmable number of pre-trigger samples and exposes a synchronous readout port ordered oldest-first.

Parameters:
DATA_W, 18, probe bus width in bits (1..64)
DEPTH, 256, capture depth in samples; power of two, 4..4096
ADDR_W, $clog2(DEPTH), buffer address width; derived, do not override

Ports:
i_clk  in  1  sample and logic clock
i_rst  in  1  asynchronous reset, active-high
i_data  in  DATA_W  probe bus
i_arm  in  1  start capture; pulse
i_abort  in  1  return to IDLE from any state
i_trig_mode  in  2  0=level, 1=edge, 2=change, 3=force
i_trig_mask  in  DATA_W  bits taking part in the trigger
i_trig_value  in  DATA_W  compare value for level/edge
i_pretrig  in  ADDR_W  number of samples kept before the trigger
o_armed  out  1  high in PRE or WAIT_TRIG
o_triggered  out  1  high in POST or DONE
o_done  out  1  high in DONE
o_trig_addr  out  ADDR_W  physical buffer address of the trigger sample
i_rd_en  in  1  read request
i_rd_addr  in  ADDR_W  logical index k; 0 is the oldest sample
o_rd_data  out  DATA_W  read data
o_rd_valid  out  1  read data valid

Behaviour:
- Reset (async, i_rst=1): state=IDLE, all outputs 0, write pointer 0, previous-data and previous-match registers 0.
- Configuration (mode, mask, value, pretrig) is latched on the arm edge. Inputs changing later have no effect until the next arm.
- i_pretrig is clamped to DEPTH-1.
- FSM states: IDLE, PRE, WAIT_TRIG, POST, DONE.
- i_abort has priority over every other input: next state IDLE, capture contents discarded, o_trig_addr kept.
- IDLE / DONE + i_arm -> PRE:
  - write pointer := 0, pre counter := latched pretrig.
  - The first sample is written on the next clock edge.
  - i_arm in PRE, WAIT_TRIG or POST is ignored.
- PRE: write i_data at the write pointer every cycle, then increment the pointer (wraps mod DEPTH).
  - Go to WAIT_TRIG once pretrig samples are written.
  - If pretrig=0, go straight from arm to WAIT_TRIG.
  - Trigger conditions are ignored in PRE.
- WAIT_TRIG: write a sample every cycle, circularly, and evaluate the trigger on the same-cycle i_data:
  - match = ((i_data ^ value) & mask) == 0
  - level: match
  - edge: match & ~prev_match
  - change: ((i_data ^ prev_data) & mask) != 0
  - force: 1 on the first WAIT_TRIG cycle
  - On trigger, the sample written this cycle is the trigger sample: o_trig_addr := write pointer, post counter := DEPTH-1-pretrig.
  - Next state is POST, or DONE if the post count is 0.
- prev_data and prev_match update every cycle in every state. An edge or change therefore refers to the immediately preceding i_clk cycle.
- POST: write one sample per cycle, decrement the post counter; go to DONE after the last sample is written. A full capture is exactly DEPTH samples: pretrig before, the trigger sample, then the rest after.
- DONE: no writes. The buffer holds its contents until the next arm.
- Readout:
  - Physical address = (o_trig_addr - pretrig + k) mod DEPTH, in ADDR_W-bit wrap arithmetic.
  - i_rd_en in DONE: o_rd_data and o_rd_valid=1 appear on the following cycle (1-cycle latency, one word per cycle, back-to-back reads allowed).
  - i_rd_en outside DONE: o_rd_valid=0, o_rd_data holds its previous value.
  - o_rd_valid stays low in any cycle with no read.
- Simultaneous events:
  - abort+arm in IDLE: stays IDLE.
  - Trigger on the final PRE cycle is ignored.
  - With pretrig=DEPTH-1, DONE is entered the cycle after the trigger.
- Reset mid-capture: immediate IDLE, outputs 0, buffer RAM content undefined.
- Buffer is inferred simple dual-port BSRAM: write in the capture path, synchronous read.

Test Plan:
- Level trigger (DATA_W=8, DEPTH=16): i_data counts 0,1,2… from the first post-arm sample; pretrig=4, mask=FF, value=0A. Expected:
  - o_trig_addr=10, o_done asserted after sample 0x15.
  - Reads k=0->06, k=4->0A, k=15->15.
- Edge vs level: i_data held at 0A before arm; mode=edge, value=0A.
  - No trigger while 0A holds.
  - After i_data goes 00 then 0A, trigger fires on the 0A cycle; read k=pretrig returns 0A.
- Change mode with mask=01: counter input with pretrig=0 and the trigger forced to the first WAIT_TRIG cycle via an odd/even start.
  - Trigger fires on the first LSB toggle; k=0 equals the trigger value.
  - Changes in mask-excluded bits alone never trigger.
- Wrap-around: level trigger that needs ~40 cycles (DEPTH=16, pretrig=8).
  - Trigger sample at physical address (40 mod 16).
  - Logical reads return 8 contiguous pre-trigger values, the trigger value, then 7 post values, in order.
- Boundaries:
  - pretrig=0 with force: k=0 is the first post-arm sample.
  - pretrig=15: DONE one cycle after the trigger, k=15 is the trigger sample.
  - i_pretrig=15 at DEPTH=16 is used as-is (clamp only applies above DEPTH-1).
- Control and reset:
  - i_abort in POST -> IDLE next cycle; reads give o_rd_valid=0.
  - i_arm during WAIT_TRIG is ignored.
  - Async i_rst asserted mid-POST clears o_armed, o_triggered and o_done without waiting for a clock edge.
  - Re-arm from DONE starts a fresh capture.
